serial_alu_ctrl: RTL and testbench
==================================

# serial_alu_ctrl

Bit-serial sequencer that performs a WIDTH-bit ALU operation by stepping the team's 1-bit ALU slice once per clock, LSB first, chaining carry/borrow through a register. It sits between a requesting master (start/done handshake) and a single shared 1-bit ALU instance. It trades latency (WIDTH cycles) for area in the 8-bit ALU project.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  operation code, captured with start.
- a  in  WIDTH  operand A, captured with start.
- b  in  WIDTH  operand B, captured with start.
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle pulse; result/flags valid from this cycle.
- result  out  WIDTH  operation result; held until the next accepted start.
- carry  out  1  final carry (ADD) or final borrow (SUB); 0 for all other ops.
- zero  out  1  high when result == 0; held with result.

## Operation
- Op codes: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB (A-B), 101 PASS_A, 110 PASS_B, 111 NOT_A. All 8 codes are legal.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start=1, capture a, b, op into shift registers, clear bit counter, clear carry register, go to RUN.
  - RUN: feed bit 0 of each operand shift register, plus the carry register, to the slice. Shift the slice result into the MSB of the result shift register, shifting it right. Shift the operands right. Increment the counter. When counter == WIDTH-1, go to DONE.
  - DONE: assert done for one cycle; next edge returns to IDLE unconditionally.
- Carry chain:
  - Slice carry-in is the carry register for ADD and SUB; it is 0 for all other ops.
  - The carry register loads the slice carry-out only for ADD/SUB. For other ops it stays 0, and slice carry-out is ignored. The slice drives carry-out=1 for NOT_A, so this masking is mandatory.
  - SUB: the slice's carry-out is a borrow. The initial borrow is 0, and the final borrow appears on carry.
- zero is computed from the completed result and registered on entry to DONE.
- start is ignored in RUN and DONE; there is no queueing. op/a/b may change freely after the capture edge.

## Timing
- Reset values: state IDLE; busy=0, done=0, result=0, carry=0, zero=0; internal counter and shift registers 0.
- Latency:
  - Start is sampled at edge 0.
  - Edges 1..WIDTH compute bits 0..WIDTH-1.
  - State becomes DONE at edge WIDTH, so done is high in the cycle following edge WIDTH.
  - Throughput is one operation per WIDTH+2 cycles when start is held high.
- busy rises at edge 0 and falls at edge WIDTH. busy and done are never high together.
- result, carry and zero update only at edge WIDTH. They are stable from the done cycle until WIDTH edges after the next accepted start.
- Reset asserted mid-operation aborts immediately, with all outputs at reset values. No done pulse is issued for the aborted op.
- Counter width is clog2(WIDTH). No wrap beyond WIDTH-1 is possible.

## Structure
- Shared package alu_pkg holds the op-code localparams (OP_AND..OP_NOT_A) and the FSM state encoding. These are shared with the parallel 8-bit ALU and its bench.
- One sub-module instance, bit_1_alu, is the natural datapath.
  - Inputs: A, B, Cin, 3-bit ALU_Sel.
  - Outputs: Result, Cout.
  - It is purely combinational.
- The controller contains only the FSM, counter, operand/result shift registers, carry register and flag logic.

## Test plan
- ADD, WIDTH=8, a=0xFF, b=0x01 -> done at edge 8 only, result=0x00, carry=1, zero=1; busy high for edges 0..7.
- SUB a=0x05, b=0x07 -> result=0xFE, carry=1 (borrow), zero=0; then SUB 0x07-0x05 -> 0x02, carry=0.
- NOT_A a=0xA5 -> result=0x5A, carry=0; XOR a=0x3C, b=0x3C -> result=0x00, zero=1, carry=0.
- Pulse start with new operands during RUN and during DONE -> ignored, result matches the first op; start held high -> second op accepted in IDLE, done pulses 10 cycles apart.
- Assert rst_n=0 at edge 4 of an ADD -> all outputs 0 immediately, no done; after release, a fresh ADD 0x12+0x34 -> 0x46, carry=0.
- Random sweep over all 8 ops, 1000 operand pairs -> result/carry/zero match the reference model; done is exactly one cycle wide.

Source files
------------

// File: rtl/serial_alu_ctrl_pkg.sv
// Shared definitions for the ALU family: op codes and the serial controller's
// FSM encoding. The parallel 8-bit ALU and its bench import the same package.
package alu_pkg;

    localparam logic [2:0] OP_AND    = 3'b000;
    localparam logic [2:0] OP_OR     = 3'b001;
    localparam logic [2:0] OP_XOR    = 3'b010;
    localparam logic [2:0] OP_ADD    = 3'b011;
    localparam logic [2:0] OP_SUB    = 3'b100;
    localparam logic [2:0] OP_PASS_A = 3'b101;
    localparam logic [2:0] OP_PASS_B = 3'b110;
    localparam logic [2:0] OP_NOT_A  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Only ADD and SUB chain a carry/borrow between bit positions.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/serial_alu_ctrl_if.sv
// Request/response bundle between a requesting master and the serial ALU.
interface serial_alu_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result, carry, zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, carry, zero
    );
endinterface

// File: rtl/serial_alu_ctrl_bit_1_alu.sv
// Combinational 1-bit ALU slice. For SUB, Cin/Cout carry a borrow.
// NOT_A drives Cout high; callers must mask it for non-arithmetic ops.
module bit_1_alu
    import alu_pkg::*;
(
    input  logic       A,
    input  logic       B,
    input  logic       Cin,
    input  logic [2:0] ALU_Sel,
    output logic       Result,
    output logic       Cout
);

    // Per-bit function select with carry/borrow generation.
    always_comb begin
        Result = 1'b0;
        Cout   = 1'b0;
        case (ALU_Sel)
            OP_AND:    Result = A & B;
            OP_OR:     Result = A | B;
            OP_XOR:    Result = A ^ B;
            OP_ADD: begin
                Result = A ^ B ^ Cin;
                Cout   = (A & B) | (A & Cin) | (B & Cin);
            end
            OP_SUB: begin
                Result = A ^ B ^ Cin;
                Cout   = (~A & B) | (~(A ^ B) & Cin);
            end
            OP_PASS_A: Result = A;
            OP_PASS_B: Result = B;
            OP_NOT_A: begin
                Result = ~A;
                Cout   = 1'b1;
            end
            default: begin
                Result = 1'b0;
                Cout   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: steps one shared 1-bit slice LSB first over WIDTH
// cycles, chaining carry/borrow through a register. Results and flags are
// held in dedicated output registers so they stay stable while the next
// operation is being shifted through the datapath.
module serial_alu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_alu_ctrl_if.slave   bus
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    // Holds bits already computed; the bit being computed this cycle is
    // prepended to it, so one bit fewer than WIDTH is enough.
    logic [WIDTH-2:0] r_res_sh;
    logic             r_cy;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic             w_arith;
    logic             w_busy;
    logic             w_done;
    logic             w_slice_cin;
    logic             w_slice_res;
    logic             w_slice_cout;
    logic [WIDTH-1:0] w_res_full;

    assign w_arith     = is_arith(r_op);
    assign w_slice_cin = w_arith & r_cy;
    assign w_last      = (r_cnt == LAST);
    assign w_res_full  = {w_slice_res, r_res_sh};

    bit_1_alu u_slice (
        .A       (r_a_sh[0]),
        .B       (r_b_sh[0]),
        .Cin     (w_slice_cin),
        .ALU_Sel (r_op),
        .Result  (w_slice_res),
        .Cout    (w_slice_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and status decode; start is only honoured in IDLE.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Operand capture, serial shifting, carry chaining and result/flag commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_cy     <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            r_op     <= bus.op;
            r_a_sh   <= bus.a;
            r_b_sh   <= bus.b;
            r_res_sh <= '0;
            r_cnt    <= '0;
            r_cy     <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_res_sh <= w_res_full[WIDTH-1:1];
            r_cnt    <= r_cnt + CNT_W'(1);
            // Non-arithmetic ops keep the chain at 0 (NOT_A raises Cout).
            r_cy     <= w_arith & w_slice_cout;
            if (w_last) begin
                r_result <= w_res_full;
                r_carry  <= w_arith & w_slice_cout;
                r_zero   <= (w_res_full == '0);
            end
        end
    end

    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.result = r_result;
    assign bus.carry  = r_carry;
    assign bus.zero   = r_zero;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl: directed scenarios plus a random
// sweep checked against an arithmetic reference model.
module tb_serial_alu_ctrl;
    import alu_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    serial_alu_ctrl_if #(.WIDTH(W)) bus ();

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: whole-word arithmetic, not bit-serial.
    function automatic void ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b, output logic [W-1:0] r,
                                      output logic c);
        logic [W:0] wide;
        c    = 1'b0;
        wide = '0;
        case (op)
            OP_AND:    r = a & b;
            OP_OR:     r = a | b;
            OP_XOR:    r = a ^ b;
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                r    = wide[W-1:0];
                c    = wide[W];
            end
            OP_SUB: begin
                r = a - b;
                c = (a < b);
            end
            OP_PASS_A: r = a;
            OP_PASS_B: r = b;
            default:   r = ~a;
        endcase
    endfunction

    // Drives one request from IDLE and waits (bounded) for done. Must be
    // called 1 time unit after a rising edge. Returns the done latency in
    // edges (-1 on timeout), the number of busy cycles seen, whether busy and
    // done ever overlapped, and done as seen one cycle after the pulse.
    task automatic issue_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            output int lat, output int busy_cyc, output bit overlap,
                            output logic done_after);
        lat        = -1;
        busy_cyc   = 0;
        overlap    = 1'b0;
        done_after = 1'b0;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        for (int k = 1; k <= 4 * W && lat < 0; k++) begin
            if (bus.busy) busy_cyc++;
            if (bus.busy && bus.done) overlap = 1'b1;
            @(posedge clk); #1;
            if (bus.done) begin
                lat = k;
                if (bus.busy) overlap = 1'b1;
            end
        end
        @(posedge clk); #1;
        done_after = bus.done;
        $display("op=%0d a=%h b=%h -> result=%h carry=%b zero=%b latency=%0d",
                 op, a, b, bus.result, bus.carry, bus.zero, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.busy !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0)  begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        total++; if (bus.result !== '0)  begin bad++; $display("FAIL reset_result: got %h want 00", bus.result); end
        total++; if (bus.carry !== 1'b0) begin bad++; $display("FAIL reset_carry: got %b want 0", bus.carry); end
        total++; if (bus.zero !== 1'b0)  begin bad++; $display("FAIL reset_zero: got %b want 0", bus.zero); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if ({bus.busy, bus.done} !== 2'b00) begin bad++; $display("FAIL idle_after_reset: busy/done=%b want 00", {bus.busy, bus.done}); end
        $display("reset sequence complete");
    endtask

    task automatic test_add_overflow();
        int lat, bc; bit ov; logic da;
        issue_op(OP_ADD, 8'hFF, 8'h01, lat, bc, ov, da);
        total++; if (lat != W)            begin bad++; $display("FAIL add_latency: got %0d want %0d", lat, W); end
        total++; if (bc != W)             begin bad++; $display("FAIL add_busy_cycles: got %0d want %0d", bc, W); end
        total++; if (ov)                  begin bad++; $display("FAIL add_busy_done_overlap: got 1 want 0"); end
        total++; if (da !== 1'b0)         begin bad++; $display("FAIL add_done_width: got %b want 0", da); end
        total++; if (bus.result !== 8'h00) begin bad++; $display("FAIL add_result: got %h want 00", bus.result); end
        total++; if (bus.carry !== 1'b1)  begin bad++; $display("FAIL add_carry: got %b want 1", bus.carry); end
        total++; if (bus.zero !== 1'b1)   begin bad++; $display("FAIL add_zero: got %b want 1", bus.zero); end
    endtask

    task automatic test_sub();
        int lat, bc; bit ov; logic da;
        issue_op(OP_SUB, 8'h05, 8'h07, lat, bc, ov, da);
        total++; if (bus.result !== 8'hFE) begin bad++; $display("FAIL sub1_result: got %h want fe", bus.result); end
        total++; if (bus.carry !== 1'b1)   begin bad++; $display("FAIL sub1_borrow: got %b want 1", bus.carry); end
        total++; if (bus.zero !== 1'b0)    begin bad++; $display("FAIL sub1_zero: got %b want 0", bus.zero); end
        issue_op(OP_SUB, 8'h07, 8'h05, lat, bc, ov, da);
        total++; if (bus.result !== 8'h02) begin bad++; $display("FAIL sub2_result: got %h want 02", bus.result); end
        total++; if (bus.carry !== 1'b0)   begin bad++; $display("FAIL sub2_borrow: got %b want 0", bus.carry); end
    endtask

    task automatic test_not_xor();
        int lat, bc; bit ov; logic da;
        issue_op(OP_NOT_A, 8'hA5, 8'h00, lat, bc, ov, da);
        total++; if (bus.result !== 8'h5A) begin bad++; $display("FAIL not_result: got %h want 5a", bus.result); end
        total++; if (bus.carry !== 1'b0)   begin bad++; $display("FAIL not_carry: got %b want 0", bus.carry); end
        issue_op(OP_XOR, 8'h3C, 8'h3C, lat, bc, ov, da);
        total++; if (bus.result !== 8'h00) begin bad++; $display("FAIL xor_result: got %h want 00", bus.result); end
        total++; if (bus.zero !== 1'b1)    begin bad++; $display("FAIL xor_zero: got %b want 1", bus.zero); end
        total++; if (bus.carry !== 1'b0)   begin bad++; $display("FAIL xor_carry: got %b want 0", bus.carry); end
    endtask

    task automatic test_ignore_start();
        int lat = -1;
        bus.start = 1'b1; bus.op = OP_ADD; bus.a = 8'h10; bus.b = 8'h20;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Pulse during RUN with different operands.
        bus.start = 1'b1; bus.op = OP_SUB; bus.a = 8'h01; bus.b = 8'h77;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 5; k <= 4 * W && lat < 0; k++) begin
            @(posedge clk); #1;
            if (bus.done) lat = k;
        end
        total++; if (lat != W)             begin bad++; $display("FAIL ignore_run_latency: got %0d want %0d", lat, W); end
        total++; if (bus.result !== 8'h30) begin bad++; $display("FAIL ignore_run_result: got %h want 30", bus.result); end
        total++; if (bus.carry !== 1'b0)   begin bad++; $display("FAIL ignore_run_carry: got %b want 0", bus.carry); end
        // Pulse during DONE.
        bus.start = 1'b1; bus.op = OP_XOR; bus.a = 8'hFF; bus.b = 8'h0F;
        @(posedge clk); #1;
        bus.start = 1'b0;
        total++; if (bus.busy !== 1'b0)    begin bad++; $display("FAIL ignore_done_busy: got %b want 0", bus.busy); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.busy !== 1'b0)    begin bad++; $display("FAIL ignore_done_idle: got %b want 0", bus.busy); end
        total++; if (bus.result !== 8'h30) begin bad++; $display("FAIL ignore_done_result: got %h want 30", bus.result); end
        $display("ignore-start op: result=%h latency=%0d", bus.result, lat);
    endtask

    task automatic test_back_to_back();
        int t = 0;
        int d1 = -1;
        int d2 = -1;
        logic [W-1:0] r1 = '0;
        bus.start = 1'b1; bus.op = OP_ADD; bus.a = 8'h21; bus.b = 8'h43;
        for (int k = 0; k < 6 * W && d2 < 0; k++) begin
            @(posedge clk); #1;
            t++;
            if (bus.done) begin
                if (d1 < 0) begin
                    d1 = t;
                    r1 = bus.result;
                    bus.op = OP_OR; bus.a = 8'h81; bus.b = 8'h18;
                end else begin
                    d2 = t;
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        total++; if (d1 != W + 1)          begin bad++; $display("FAIL b2b_first_done: got %0d want %0d", d1, W + 1); end
        total++; if (r1 !== 8'h64)         begin bad++; $display("FAIL b2b_first_result: got %h want 64", r1); end
        total++; if (d2 - d1 != W + 2)     begin bad++; $display("FAIL b2b_spacing: got %0d want %0d (d1=%0d d2=%0d)", d2 - d1, W + 2, d1, d2); end
        total++; if (bus.result !== 8'h99) begin bad++; $display("FAIL b2b_second_result: got %h want 99", bus.result); end
        $display("back-to-back: done at %0d and %0d, results %h %h", d1, d2, r1, bus.result);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat, bc; bit ov; logic da;
        bit seen_done = 1'b0;
        issue_op(OP_ADD, 8'h80, 8'h90, lat, bc, ov, da);
        total++; if ({bus.carry, bus.result} !== 9'h110) begin bad++; $display("FAIL pre_abort_state: got %h want 110", {bus.carry, bus.result}); end
        bus.start = 1'b1; bus.op = OP_ADD; bus.a = 8'hAA; bus.b = 8'h57;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0)  begin bad++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        total++; if (bus.result !== '0)  begin bad++; $display("FAIL abort_result: got %h want 00", bus.result); end
        total++; if (bus.carry !== 1'b0) begin bad++; $display("FAIL abort_carry: got %b want 0", bus.carry); end
        total++; if (bus.zero !== 1'b0)  begin bad++; $display("FAIL abort_zero: got %b want 0", bus.zero); end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (bus.done) seen_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (bus.done) seen_done = 1'b1;
        end
        total++; if (seen_done) begin bad++; $display("FAIL abort_no_done: got done pulse want none"); end
        issue_op(OP_ADD, 8'h12, 8'h34, lat, bc, ov, da);
        total++; if (lat != W)             begin bad++; $display("FAIL post_abort_latency: got %0d want %0d", lat, W); end
        total++; if (bus.result !== 8'h46) begin bad++; $display("FAIL post_abort_result: got %h want 46", bus.result); end
        total++; if (bus.carry !== 1'b0)   begin bad++; $display("FAIL post_abort_carry: got %b want 0", bus.carry); end
    endtask

    task automatic test_random();
        int lat, bc; bit ov; logic da;
        logic [2:0]   op;
        logic [W-1:0] a, b, exp_r;
        logic         exp_c;
        for (int n = 0; n < 1000; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = W'($urandom);
            b  = W'($urandom);
            if ($urandom_range(0, 7) == 0) b = a;
            ref_model(op, a, b, exp_r, exp_c);
            issue_op(op, a, b, lat, bc, ov, da);
            total++; if (bus.result !== exp_r) begin bad++; $display("FAIL rnd_result op=%0d a=%h b=%h: got %h want %h", op, a, b, bus.result, exp_r); end
            total++; if (bus.carry !== exp_c)  begin bad++; $display("FAIL rnd_carry op=%0d a=%h b=%h: got %b want %b", op, a, b, bus.carry, exp_c); end
            total++; if (bus.zero !== (exp_r == '0)) begin bad++; $display("FAIL rnd_zero op=%0d a=%h b=%h: got %b want %b", op, a, b, bus.zero, exp_r == '0); end
            total++; if (lat != W)             begin bad++; $display("FAIL rnd_latency op=%0d: got %0d want %0d", op, lat, W); end
            total++; if (da !== 1'b0 || ov)    begin bad++; $display("FAIL rnd_done_pulse op=%0d: done_after=%b overlap=%b want 0 0", op, da, ov); end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        test_reset();
        test_add_overflow();
        test_sub();
        test_not_xor();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
